// File: rtl/up_down_counter.sv
// Parametrised up/down counter with clear, load, count enable, registered wrap pulse and sticky overflow.
// Build option: define UP_DOWN_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module up_down_counter #(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_load_ext;
  logic [WIDTH:0]   w_load_lim;
  logic             w_up_blocked;
  logic             w_dn_blocked;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_ovf_next;

  assign w_cnt_ext    = {1'b0, r_count};
  assign w_inc        = w_cnt_ext + 1'b1;
  assign w_dec        = w_cnt_ext - 1'b1;
  // The extra bit catches both bounds: an increment past MAX_COUNT, or a borrow out of zero.
  assign w_up_blocked = (w_inc > MAX_W);
  assign w_dn_blocked = w_dec[WIDTH];
  assign w_load_ext   = {1'b0, load_val};
  assign w_load_lim   = (w_load_ext > MAX_W) ? MAX_W : w_load_ext;

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (clr) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_load_lim[WIDTH-1:0];
    end else if (en) begin
      if (up_dn) begin
        if (w_up_blocked) begin
          w_wrap_next = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          w_count_next = r_count;
`else
          w_count_next = '0;
`endif
        end else begin
          w_count_next = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_dn_blocked) begin
          w_wrap_next = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          w_count_next = '0;
`else
          w_count_next = MAX_W[WIDTH-1:0];
`endif
        end else begin
          w_count_next = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  // A wrap on the same edge as ovf_clr leaves the flag set.
  assign w_ovf_next = w_wrap_next | (r_ovf & ~ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign ovf     = r_ovf;
  assign at_max  = (r_count == MAX_W[WIDTH-1:0]);
  assign at_zero = (r_count == '0);

endmodule

// File: doc/up_down_counter.md
# up_down_counter

Parametrised synchronous up/down counter, the next generation of the fixed 4-bit `up_counter`. Adds configurable width and modulus, count enable, direction control, synchronous clear and parallel load, a registered wrap pulse and a sticky overflow flag. Used as a general event or timer counter wherever the 4-bit block is too narrow or lacks control.

## Interface
- `WIDTH`, default 8: counter width in bits, 2..32.
- `MAX_COUNT`, default 2**WIDTH-1: highest count value, 1..2**WIDTH-1. Counting is modulo MAX_COUNT+1.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clr` input, 1 bit: synchronous clear.
- `load` input, 1 bit: synchronous parallel load.
- `load_val` input, WIDTH bits: value to load.
- `en` input, 1 bit: count enable.
- `up_dn` input, 1 bit: direction, 1 = up, 0 = down.
- `ovf_clr` input, 1 bit: clears the sticky `ovf` flag.
- `count` output, WIDTH bits: current count, registered.
- `wrap` output, 1 bit: one-cycle pulse, registered.
- `ovf` output, 1 bit: sticky flag, set by any wrap event.
- `at_max` output, 1 bit: combinational, `count == MAX_COUNT`.
- `at_zero` output, 1 bit: combinational, `count == 0`.

## Operation
- Reset (`rst_n` low): `count`=0, `wrap`=0, `ovf`=0, taking effect immediately without a clock. Release is synchronous to the next rising edge.
- Per-edge priority, highest first: `clr` > `load` > `en` > hold.
- `clr`: `count`←0, `wrap`←0. `ovf` is unaffected.
- `load`: `count`←min(`load_val`, MAX_COUNT), `wrap`←0.
- Count up (`en`=1, `up_dn`=1):
  - `count`<MAX_COUNT: `count`+1.
  - `count`=MAX_COUNT: `count`←0 and `wrap`←1.
- Count down (`en`=1, `up_dn`=0):
  - `count`>0: `count`-1.
  - `count`=0: `count`←MAX_COUNT and `wrap`←1.
- Hold (`en`=0): `count` holds, `wrap`←0.
- `wrap` is high for exactly one cycle per wrap event. Back-to-back wraps keep it high on consecutive cycles, e.g. MAX_COUNT=1 counting up continuously.
- `ovf`:
  - Set on any cycle where `wrap` is being set.
  - Cleared by `ovf_clr`.
  - If a wrap and `ovf_clr` occur on the same edge, set wins.
- Arithmetic is done in WIDTH+1 bits internally. `count` never exceeds MAX_COUNT.
- A direction change takes effect on the next edge; there is no dead cycle.

## Timing
- `count`, `wrap` and `ovf` update on the rising `clk` edge after the qualifying input, giving 1-cycle latency.
- `at_max` and `at_zero` follow `count` combinationally in the same cycle.
- All inputs must be synchronous to `clk`; there is no internal synchroniser.
- `rst_n` asserted mid-count clears all state immediately, including a `wrap` pulse in flight.

## Configuration
- Macro: `UP_DOWN_COUNTER_SATURATE_EN`.
- Defined: saturating mode.
  - Up at MAX_COUNT holds MAX_COUNT.
  - Down at 0 holds 0.
  - `wrap` pulses on each enabled cycle where a step is blocked at a bound.
  - `ovf` sets as normal.
- Undefined: modulo wrap behaviour as described in Operation.
- `clr` and `load` behave identically in both modes.

## Test plan
- Reset and up count:
  - Stimulus: WIDTH=4, MAX_COUNT=15, `rst_n` low for 12 ns, then `en`=1, `up_dn`=1 for 20 cycles.
  - Required: `count` 0,1,…,15,0,1,2,3; `wrap` high only on the cycle `count` shows 0 after 15; `ovf`=1 from then on.
- Modulus and down count:
  - Stimulus: MAX_COUNT=9, load 2, then count down 4 cycles.
  - Required: `count` 2,1,0,9,8; `wrap` pulses once when 9 appears; `at_zero` high only while `count`=0.
- Priority:
  - Stimulus: `clr`=1, `load`=1 with `load_val`=5, `en`=1 on the same edge.
  - Required: `count`=0.
  - Stimulus: then `load`=1 with `en`=1.
  - Required: `count`=5.
  - Stimulus: `load_val`=14 with MAX_COUNT=9.
  - Required: `count`=9.
- Sticky overflow:
  - Stimulus: force a wrap; assert `ovf_clr` on the same edge as a second wrap.
  - Required: `ovf` stays 1.
  - Stimulus: `ovf_clr` on a non-wrap cycle.
  - Required: `ovf`=0 next cycle.
- Asynchronous reset mid-run:
  - Stimulus: drop `rst_n` mid-cycle at `count`=7 while `wrap` is high.
  - Required: `count`, `wrap` and `ovf` all 0 before the next edge; counting resumes from 0 after release.
- Saturate build (`UP_DOWN_COUNTER_SATURATE_EN` defined):
  - Stimulus: count up past 15.
  - Required: `count` holds 15, with `wrap` high each blocked cycle.
  - Stimulus: count down from 0.
  - Required: `count` holds 0.
